serial_subtractor: RTL and testbench

Multi-cycle, bit-serial WIDTH-bit subtractor computing out = in1 - in2 (two's complement: in1 + ~in2 + 1). It processes one bit per clock through a single full-adder cell. It is the area-reduced counterpart to the combinational ripple adder in the arithmetic library. A start/busy/done handshake lets a controller issue operations without tracking latency. It reports unsigned borrow and signed overflow.

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (in1 - in2) built around one full-adder cell.
// Define SERIAL_ADDSUB_MODE_EN to add a 'sub' port that selects add (0) or subtract (1).
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDSUB_MODE_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       overflow_bit
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             carry;
    logic             sub_r;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_out;
    logic             last_bit;
    logic             accept;
    logic             load_sub;

`ifdef SERIAL_ADDSUB_MODE_EN
    assign load_sub = sub;
`else
    assign load_sub = 1'b1;
`endif

    // A start is honoured in IDLE and DONE alike, so back-to-back ops need no gap cycle.
    assign accept = start && (state != SHIFT);

    always_comb begin
        sum_bit   = a[0] ^ b[0] ^ carry;
        carry_out = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? SHIFT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // On the final shift the current carry is the carry into the MSB, which gives signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a            <= '0;
            b            <= '0;
            r            <= '0;
            carry        <= 1'b0;
            sub_r        <= 1'b0;
            cnt          <= '0;
            out          <= '0;
            overflow_bit <= 2'b00;
        end else if (accept) begin
            a     <= in1;
            b     <= load_sub ? ~in2 : in2;
            carry <= load_sub;
            sub_r <= load_sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            r     <= {sum_bit, r[WIDTH-1:1]};
            a     <= a >> 1;
            b     <= b >> 1;
            carry <= carry_out;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                out          <= {sum_bit, r[WIDTH-1:1]};
                overflow_bit <= {carry ^ carry_out, carry_out ^ sub_r};
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard testbench for serial_subtractor (WIDTH=16); define SERIAL_ADDSUB_MODE_EN to also test add mode.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [1:0]  overflow_bit;
`ifdef SERIAL_ADDSUB_MODE_EN
    logic        sub;
`endif

    typedef struct {
        logic [15:0] res;
        logic [1:0]  ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks;
    int   failures;

    serial_subtractor #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef SERIAL_ADDSUB_MODE_EN
        .sub          (sub),
`endif
        .in1          (in1),
        .in2          (in2),
        .busy         (busy),
        .done         (done),
        .out          (out),
        .overflow_bit (overflow_bit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference subtract: borrow is an unsigned compare, overflow a sign-rule check.
    function automatic exp_t modelSub(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e.res    = x - y;
        e.ovf[0] = (x < y);
        e.ovf[1] = (x[15] != y[15]) && (e.res[15] != x[15]);
        return e;
    endfunction

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic mode,
                                 input logic [15:0] exp_res, input logic [1:0] exp_ovf);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        in1   = x;
        in2   = y;
`ifdef SERIAL_ADDSUB_MODE_EN
        sub   = mode;
`endif
        e.res = exp_res;
        e.ovf = exp_ovf;
        sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic runOp(input logic [15:0] x, input logic [15:0] y, input logic mode,
                         input logic [15:0] exp_res, input logic [1:0] exp_ovf);
        int n;
        applyStimulus(x, y, mode, exp_res, exp_ovf);
        waitDone(n);
        checkOutput("latency", 32'(n), 32'd17);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            checkOutput("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("out", 32'(out), 32'(e.res));
                checkOutput("overflow_bit", 32'(overflow_bit), 32'(e.ovf));
            end
        end
    end

    initial begin
        int   n;
        exp_t m;
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in1      = '0;
        in2      = '0;
`ifdef SERIAL_ADDSUB_MODE_EN
        sub      = 1'b1;
`endif
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_out", 32'(out), 32'd0);
        checkOutput("rst_ovf", 32'(overflow_bit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(16'h0005, 16'h0003, 1'b1, 16'h0002, 2'b00);
        runOp(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 2'b01);
        runOp(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 2'b10);
        runOp(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 2'b11);
        runOp(16'h1234, 16'h1234, 1'b1, 16'h0000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = 16'($urandom);
            m = modelSub(x, y);
            runOp(x, y, 1'b1, m.res, m.ovf);
        end

        // A start pulse mid-operation must be dropped; only the first operands matter.
        applyStimulus(16'h00A0, 16'h0050, 1'b1, 16'h0050, 2'b00);
        repeat (5) @(negedge clk);
        start = 1'b1;
        in1   = 16'hFFFF;
        in2   = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        waitDone(n);
        checkOutput("latency_ignored", 32'(n), 32'd11);
        repeat (20) @(negedge clk);
        checkOutput("idle_after_ignored", 32'(busy), 32'd0);

        m = modelSub(16'h4321, 16'h1111);
        applyStimulus(16'h4321, 16'h1111, 1'b1, m.res, m.ovf);
        start = 1'b1;
        waitDone(n);
        checkOutput("latency_b2b_first", 32'(n), 32'd17);
        m = modelSub(16'h0001, 16'h8000);
        in1 = 16'h0001;
        in2 = 16'h8000;
        sbq.push_back(m);
        waitDone(n);
        checkOutput("period_b2b", 32'(n), 32'd17);
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle", 32'(busy), 32'd0);

        applyStimulus(16'h5555, 16'h1111, 1'b1, 16'h4444, 2'b00);
        void'(sbq.pop_back());
        repeat (5) @(negedge clk);
        checkOutput("midop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_out", 32'(out), 32'd0);
        checkOutput("abort_ovf", 32'(overflow_bit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("abort_idle", 32'(busy), 32'd0);

`ifdef SERIAL_ADDSUB_MODE_EN
        runOp(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 2'b01);
        runOp(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 2'b10);
        runOp(16'h0005, 16'h0003, 1'b1, 16'h0002, 2'b00);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
